// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, line levels and a counter-width helper.
// The serial receiver imports this package as well.
package uart_defs;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is asserted so a new bit always starts on a fresh count.
module uart_bit_timer
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int              CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLKS_PER_BIT=1 the count stays at zero and every cycle is a bit end.
    assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART-style transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Every output is a register whose next value is decoded from the next FSM state.
module uart_tx_serializer
    import uart_defs::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int            IW       = cnt_width(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    logic [2:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic [IW-1:0]         idx_q,    idx_d;
    logic                  parity_q, parity_d;
    logic                  serial_q, serial_d;
    logic                  ready_q,  ready_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  accept;
    logic                  timer_clear;
    logic                  bit_end;

    assign accept      = tx_valid && ready_q;
    assign timer_clear = (state_q == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    idx_d    = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so it changes on the same edge.
        case (state_d)
            START:   serial_d = START_LEVEL;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            default: serial_d = IDLE_LEVEL;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            serial_q <= IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Parallel-to-serial transmitter. Accepts a DATA_WIDTH word on a valid/ready handshake and drives it onto a single serial line as a framed, UART-style bit stream.
- Frame order: start bit (0), data bits LSB-first, optional even-parity bit, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- It is the transmit end feeding the team's serial receiver / SIPO capture logic.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal range 1..16)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (legal range >= 1)
- PARITY_EN, 0, 1 inserts an even-parity bit after the data; 0 omits it

Ports:
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- tx_data  input  DATA_WIDTH  word to send; sampled only on handshake
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word this cycle
- serial_out  output  1  serial line, idle high
- tx_busy  output  1  a frame is in progress (START..STOP)
- tx_done  output  1  one-cycle pulse on the first IDLE cycle after a completed frame

Behaviour:
- Reset values: serial_out=1, tx_ready=1, tx_busy=0, tx_done=0. FSM=IDLE, shift register and counters cleared.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, serial_out=1.
  - On tx_valid && tx_ready, tx_data is captured into the shift register and parity = XOR of tx_data is captured.
  - Next cycle: state START, serial_out=0, tx_ready=0, tx_busy=1.
- Bit timing: a clock counter runs 0..CLKS_PER_BIT-1 within each bit. The state advances only when the counter equals CLKS_PER_BIT-1, and the counter then wraps to 0.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA:
  - serial_out = shift_reg[0]; the register shifts right at each bit boundary.
  - A bit index counts 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1 completes: go to PARITY if PARITY_EN, else STOP.
- PARITY: serial_out = captured even-parity bit, held CLKS_PER_BIT cycles, then STOP.
- STOP:
  - serial_out=1 for CLKS_PER_BIT cycles, then IDLE.
  - The IDLE-entry cycle has tx_done=1, tx_ready=1, tx_busy=0.
- Latency: serial_out falls exactly 1 clock after the accepting edge.
- Frame length: CLKS_PER_BIT*(DATA_WIDTH+2+PARITY_EN) clocks.
- Back-to-back: a word presented during the tx_done cycle is accepted. The line then stays high for exactly 1 clock between the stop bit and the next start bit.
- tx_valid while tx_ready=0 is ignored (no capture, no queuing). tx_data changes after acceptance do not affect the frame in flight.
- Reset mid-frame: on the next edge serial_out=1, tx_ready=1, tx_busy=0, tx_done=0. The in-flight word is discarded and no tx_done is generated for it.
- reset has priority over a simultaneous tx_valid; the word is not accepted.
- CLKS_PER_BIT=1: every bit lasts exactly one clock. The counter logic must not underflow.
- Counter widths are derived with $clog2 of CLKS_PER_BIT and DATA_WIDTH, with a minimum of 1 bit.

Decomposition:
- Shared package/include uart_defs:
  - FSM state encodings as localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
  - Line levels IDLE_LEVEL=1 and START_LEVEL=0.
  - Receiver reuses this package.
- One natural sub-module, uart_bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs clock, reset, clear.
  - Output bit_end pulses on the last cycle of each bit.
  - Shared with the receiver.
- FSM and shift register stay in the top module.

Test Plan:
- Reset idle check: hold reset 3 cycles, then idle 10 cycles with tx_valid=0 -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
- Basic frame (DATA_WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0), send 8'hA5 ->
  - serial_out sequence, each bit held 4 clocks: 0,1,0,1,0,0,1,0,1,1.
  - Frame is 40 clocks. tx_done pulses once on clock 41 after acceptance.
- Parity frame (PARITY_EN=1): send 8'hA5 -> parity bit 0. Send 8'h07 -> parity bit 1. Each frame is 44 clocks.
- Back-to-back: hold tx_valid=1 with 8'h3C then 8'hC3 -> second start bit begins exactly 1 clock after the first stop bit ends. Both payloads are received intact.
- Busy rejection: pulse tx_valid with 8'hFF during the DATA state of a frame carrying 8'h00 -> line carries only 8'h00 and no second frame follows.
- Reset mid-frame: assert reset during data bit 3 -> next edge serial_out=1, tx_ready=1, no tx_done. A following send of 8'h5A transmits correctly.
